time_disp_scan: RTL and testbench
=================================

Name: time_disp_scan

Overview:
Reader side of the stopwatch time counter. It takes the three BCD time digits (seconds ones, seconds tens, minutes) and drives a time-multiplexed, common-anode 3-digit 7-segment display. It takes a tear-free snapshot of the digits once per display frame. A lap/hold function freezes the displayed time while counting continues upstream.

Parameters:
SCAN_DIV, 16, clock cycles per digit slot; legal range is 2 or more.
GHOST, 1, blanking cycles at the start of each slot with all anodes off; legal range is 0 to SCAN_DIV-1.
BLANK_LZ, 0, when 1 the minutes digit is blanked while the displayed minutes value is 0.

Ports:
CLK  in  1  single system clock; all logic on rising edge.
CLR_N  in  1  synchronous, active-low reset.
SEC_LSB  in  4  BCD seconds ones digit.
SEC_MSB  in  4  BCD seconds tens digit.
MINUTES  in  4  BCD minutes digit.
LAP  in  1  lap/hold request, level input; acted on at the rising edge.
SEG  out  7  segments {g,f,e,d,c,b,a}, active-low.
DP  out  1  decimal point, active-low.
AN  out  3  digit anodes, one-hot active-low: AN[0]=sec ones, AN[1]=sec tens, AN[2]=minutes.
HOLD  out  1  1 while the display is frozen.

Behaviour:
- Reset (CLR_N=0 at a clock edge) is synchronous, active-low and overrides everything:
  - SEG=7'b1111111, DP=1, AN=3'b111, HOLD=0.
  - State TRACK, snapshot=0/0/0, pcnt=0, dsel=0, LAP edge register=0.
  - Reset applies mid-frame or mid-HOLD with the same result.
- Prescaler pcnt counts 0..SCAN_DIV-1 and wraps. When pcnt=SCAN_DIV-1, dsel advances 0→1→2→0.
- Frame boundary = (pcnt=SCAN_DIV-1 and dsel=2).
- All outputs are registered and reflect the pcnt/dsel/snapshot state of the previous cycle (1-cycle latency).
- Slot output:
  - For pcnt<GHOST: AN=111, SEG=1111111, DP=1.
  - Otherwise: AN drives bit dsel low, and SEG shows the decode of snapshot digit dsel.
- DP=0 only during the active minutes slot, giving the M.SS separator.
- Decode (active-low):
  - 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001
  - 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000
  - Any value >9 displays E=0000110.
- BLANK_LZ=1 and snapshot minutes=0: the minutes slot keeps AN=111, SEG=1111111, DP=1. The seconds digits are never blanked.
- The lap edge is lap_rise = LAP & ~LAP_q. Holding LAP high counts once.
- FSM TRACK (HOLD=0):
  - At a frame boundary: snapshot<=inputs (all three digits in the same cycle).
  - On lap_rise: snapshot<=inputs immediately, go to HOLD. lap_rise takes precedence if it coincides with a frame boundary (single capture).
- FSM HOLD (HOLD=1):
  - Snapshot is frozen and frame boundaries are ignored.
  - On lap_rise: go to TRACK. The next capture occurs at the next frame boundary.
- HOLD output changes in the cycle after the lap_rise edge.
- Scanning continues uninterrupted in both states. LAP never resets pcnt or dsel.

Decomposition:
- Shared package (stopwatch_pkg): state encoding (TRACK, HOLD), digit index constants (DIG_SEC_LSB=0, DIG_SEC_MSB=1, DIG_MIN=2), segment pattern constants (SEG_0..SEG_9, SEG_E, SEG_BLANK).
- One sub-module: bcd_to_seg, a combinational 4-bit BCD → 7-bit active-low decoder with E for >9.
- Prescaler, FSM and output registers stay in the top block.

Test Plan:
Tests use SCAN_DIV=4, GHOST=1, BLANK_LZ=0 unless noted.
1. Reset: CLR_N=0 for 3 cycles mid-scan → AN=111, SEG=1111111, DP=1, HOLD=0. After release, first active slot shows SEG=1000000 on AN=110.
2. Inputs MIN=2, MSB=4, LSB=7; wait one frame boundary → repeating 12-cycle frame:
   - AN=111 for 1 cycle, then AN=110 with SEG=1111000 for 3 cycles.
   - AN=101 with SEG=0011001.
   - AN=011 with SEG=0100100 and DP=0.
3. Inputs 9:53, pulse LAP → HOLD=1 next cycle. Change inputs to 0:00 → display stays 9:53 for 5 frames. Second LAP pulse → HOLD=0, display shows 0:00 after the next frame boundary only.
4. LAP held high for 40 cycles → exactly one TRACK→HOLD transition. LAP asserted exactly on a frame boundary → a single capture of the LAP-cycle inputs.
5. MINUTES=4'hC → minutes slot SEG=0000110 with DP=0.
6. BLANK_LZ=1, time 0:05 → minutes slot AN=111, DP=1 throughout; seconds slots show 0 and 5.
   Then MINUTES=1 → minutes digit appears after the next frame boundary.

Source files
------------

// File: rtl/stopwatch_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : stopwatch_pkg                                          |
// | Description : Shared definitions for the stopwatch display path:     |
// |               display FSM state encoding, digit slot indices and     |
// |               active-low 7-segment patterns ({g,f,e,d,c,b,a}).       |
// | Revision    : 1.0 - initial release                                  |
// +----------------------------------------------------------------------+
package stopwatch_pkg;

  // Display FSM states: TRACK follows the counter, HOLD freezes the lap time.
  localparam logic [0:0] S_TRACK = 1'b0;
  localparam logic [0:0] S_HOLD  = 1'b1;

  // Digit slot indices, also the anode bit driven low for that slot.
  localparam logic [1:0] DIG_SEC_LSB = 2'd0;
  localparam logic [1:0] DIG_SEC_MSB = 2'd1;
  localparam logic [1:0] DIG_MIN     = 2'd2;

  // Active-low segment patterns, bit order {g,f,e,d,c,b,a}.
  localparam logic [6:0] SEG_0     = 7'b1000000;
  localparam logic [6:0] SEG_1     = 7'b1111001;
  localparam logic [6:0] SEG_2     = 7'b0100100;
  localparam logic [6:0] SEG_3     = 7'b0110000;
  localparam logic [6:0] SEG_4     = 7'b0011001;
  localparam logic [6:0] SEG_5     = 7'b0010010;
  localparam logic [6:0] SEG_6     = 7'b0000010;
  localparam logic [6:0] SEG_7     = 7'b1111000;
  localparam logic [6:0] SEG_8     = 7'b0000000;
  localparam logic [6:0] SEG_9     = 7'b0010000;
  localparam logic [6:0] SEG_E     = 7'b0000110;
  localparam logic [6:0] SEG_BLANK = 7'b1111111;

endpackage
`default_nettype wire

// File: rtl/bcd_to_seg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : bcd_to_seg                                             |
// | Description : Combinational BCD to active-low 7-segment decoder.     |
// |               Codes above 9 show the letter E.                       |
// | Ports       : bcd [3:0] in  - BCD digit                              |
// |               seg [6:0] out - segments {g,f,e,d,c,b,a}, active-low   |
// | Revision    : 1.0 - initial release                                  |
// +----------------------------------------------------------------------+
module bcd_to_seg
  import stopwatch_pkg::*;
(
  input  logic [3:0] bcd,
  output logic [6:0] seg
);

  always_comb begin
    seg = SEG_E;
    case (bcd)
      4'd0:    seg = SEG_0;
      4'd1:    seg = SEG_1;
      4'd2:    seg = SEG_2;
      4'd3:    seg = SEG_3;
      4'd4:    seg = SEG_4;
      4'd5:    seg = SEG_5;
      4'd6:    seg = SEG_6;
      4'd7:    seg = SEG_7;
      4'd8:    seg = SEG_8;
      4'd9:    seg = SEG_9;
      default: seg = SEG_E;
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/time_disp_scan.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : time_disp_scan                                         |
// | Description : Scans three BCD time digits (M.SS) onto a multiplexed  |
// |               common-anode 7-segment display. Digits are captured    |
// |               once per frame so a frame never mixes two times; LAP   |
// |               toggles a hold that freezes the shown time.            |
// | Ports       : CLK          in   system clock, rising edge            |
// |               CLR_N        in   synchronous active-low reset         |
// |               SEC_LSB[3:0] in   BCD seconds ones                     |
// |               SEC_MSB[3:0] in   BCD seconds tens                     |
// |               MINUTES[3:0] in   BCD minutes                          |
// |               LAP          in   lap/hold request, rising-edge acted  |
// |               SEG[6:0]     out  segments {g,f,e,d,c,b,a}, active-low |
// |               DP           out  decimal point, active-low            |
// |               AN[2:0]      out  one-hot active-low digit anodes      |
// |               HOLD         out  high while the display is frozen     |
// | Revision    : 1.0 - initial release                                  |
// +----------------------------------------------------------------------+
module time_disp_scan
  import stopwatch_pkg::*;
#(
  parameter int SCAN_DIV = 16,
  parameter int GHOST    = 1,
  parameter int BLANK_LZ = 0
) (
  input  logic       CLK,
  input  logic       CLR_N,
  input  logic [3:0] SEC_LSB,
  input  logic [3:0] SEC_MSB,
  input  logic [3:0] MINUTES,
  input  logic       LAP,
  output logic [6:0] SEG,
  output logic       DP,
  output logic [2:0] AN,
  output logic       HOLD
);

  localparam int PW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam logic [PW-1:0] c_pcnt_max = PW'(SCAN_DIV - 1);
  localparam logic [PW-1:0] c_ghost    = PW'(GHOST);

  logic [PW-1:0] r_pcnt;
  logic [1:0]    r_dsel;
  logic [0:0]    r_state;
  logic [0:0]    w_state_nxt;
  logic          r_lap_q;
  logic [3:0]    r_snap_lsb;
  logic [3:0]    r_snap_msb;
  logic [3:0]    r_snap_min;
  logic [6:0]    r_seg;
  logic          r_dp;
  logic [2:0]    r_an;

  logic          w_lap_rise;
  logic          w_frame_end;
  logic          w_capture;
  logic          w_hold;
  logic [3:0]    w_digit;
  logic [6:0]    w_seg_dec;
  logic          w_blank;

  assign w_lap_rise  = LAP & ~r_lap_q;
  assign w_frame_end = (r_pcnt == c_pcnt_max) && (r_dsel == DIG_MIN);

  // Slot prescaler and digit select; free-running, LAP never touches it.
  always_ff @(posedge CLK) begin
    if (!CLR_N) begin
      r_pcnt  <= '0;
      r_dsel  <= DIG_SEC_LSB;
      r_lap_q <= 1'b0;
    end else begin
      r_lap_q <= LAP;
      if (r_pcnt == c_pcnt_max) begin
        r_pcnt <= '0;
        r_dsel <= (r_dsel == DIG_MIN) ? DIG_SEC_LSB : r_dsel + 2'd1;
      end else begin
        r_pcnt <= r_pcnt + PW'(1);
      end
    end
  end

  // FSM state register
  always_ff @(posedge CLK) begin
    if (!CLR_N) begin
      r_state <= S_TRACK;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // FSM next state: every lap edge toggles between tracking and holding.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_TRACK: if (w_lap_rise) w_state_nxt = S_HOLD;
      S_HOLD:  if (w_lap_rise) w_state_nxt = S_TRACK;
      default: w_state_nxt = S_TRACK;
    endcase
  end

  // FSM outputs. A lap edge landing on a frame boundary still yields a
  // single capture because both conditions share one enable.
  always_comb begin
    w_capture = 1'b0;
    w_hold    = 1'b0;
    case (r_state)
      S_TRACK: w_capture = w_lap_rise | w_frame_end;
      S_HOLD:  w_hold    = 1'b1;
      default: w_capture = 1'b0;
    endcase
  end

  assign HOLD = w_hold;

  // All three digits are taken in the same cycle so the frame is tear-free.
  always_ff @(posedge CLK) begin
    if (!CLR_N) begin
      r_snap_lsb <= 4'd0;
      r_snap_msb <= 4'd0;
      r_snap_min <= 4'd0;
    end else if (w_capture) begin
      r_snap_lsb <= SEC_LSB;
      r_snap_msb <= SEC_MSB;
      r_snap_min <= MINUTES;
    end
  end

  always_comb begin
    w_digit = r_snap_lsb;
    case (r_dsel)
      DIG_SEC_LSB: w_digit = r_snap_lsb;
      DIG_SEC_MSB: w_digit = r_snap_msb;
      DIG_MIN:     w_digit = r_snap_min;
      default:     w_digit = r_snap_lsb;
    endcase
  end

  bcd_to_seg u_dec (
    .bcd (w_digit),
    .seg (w_seg_dec)
  );

  // Ghost interval at the start of each slot hides segment turn-over;
  // optional leading-zero blanking applies to the minutes slot only.
  assign w_blank = (r_pcnt < c_ghost) ||
                   ((BLANK_LZ != 0) && (r_dsel == DIG_MIN) && (r_snap_min == 4'd0));

  always_ff @(posedge CLK) begin
    if (!CLR_N) begin
      r_an  <= 3'b111;
      r_seg <= SEG_BLANK;
      r_dp  <= 1'b1;
    end else if (w_blank) begin
      r_an  <= 3'b111;
      r_seg <= SEG_BLANK;
      r_dp  <= 1'b1;
    end else begin
      r_an  <= ~(3'b001 << r_dsel);
      r_seg <= w_seg_dec;
      r_dp  <= (r_dsel == DIG_MIN) ? 1'b0 : 1'b1;
    end
  end

  assign AN  = r_an;
  assign SEG = r_seg;
  assign DP  = r_dp;

endmodule
`default_nettype wire

// File: tb/tb_time_disp_scan.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : tb_time_disp_scan                                      |
// | Description : Directed self-checking bench for time_disp_scan with   |
// |               SCAN_DIV=4, GHOST=1; a second instance has BLANK_LZ=1. |
// | Revision    : 1.0 - initial release                                  |
// +----------------------------------------------------------------------+
module tb_time_disp_scan;

  localparam logic [6:0] S0 = 7'b1000000, S1 = 7'b1111001, S2 = 7'b0100100,
                         S3 = 7'b0110000, S4 = 7'b0011001, S5 = 7'b0010010,
                         S6 = 7'b0000010, S7 = 7'b1111000, S8 = 7'b0000000,
                         S9 = 7'b0010000, SE = 7'b0000110, SB = 7'b1111111;

  logic       clk = 1'b0;
  logic       clr_n;
  logic [3:0] sec_lsb, sec_msb, minutes;
  logic       lap;
  logic [6:0] seg_a, seg_b;
  logic       dp_a, dp_b, hold_a, hold_b;
  logic [2:0] an_a, an_b;

  int total = 0;
  int bad   = 0;
  int k     = 0;   // clock edges since reset release

  always #5 clk = ~clk;

  time_disp_scan #(.SCAN_DIV(4), .GHOST(1), .BLANK_LZ(0)) u_dut (
    .CLK(clk), .CLR_N(clr_n), .SEC_LSB(sec_lsb), .SEC_MSB(sec_msb),
    .MINUTES(minutes), .LAP(lap), .SEG(seg_a), .DP(dp_a), .AN(an_a), .HOLD(hold_a)
  );

  time_disp_scan #(.SCAN_DIV(4), .GHOST(1), .BLANK_LZ(1)) u_dut_lz (
    .CLK(clk), .CLR_N(clr_n), .SEC_LSB(sec_lsb), .SEC_MSB(sec_msb),
    .MINUTES(minutes), .LAP(lap), .SEG(seg_b), .DP(dp_b), .AN(an_b), .HOLD(hold_b)
  );

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", tag, obs, exp, k);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    k++;
  endtask

  // Position (0..11) within the 12-cycle frame of the outputs now visible.
  function automatic int ph();
    return (k - 1) % 12;
  endfunction

  task automatic set_time(input logic [3:0] m, input logic [3:0] t, input logic [3:0] o);
    minutes = m;
    sec_msb = t;
    sec_lsb = o;
  endtask

  // Compare {AN,DP,SEG} of one instance against the expected slot output.
  task automatic check_now(input string tag, input bit lz, input logic [6:0] e0,
                           input logic [6:0] e1, input logic [6:0] e2, input bit blank_min);
    int slot, pos;
    logic [2:0] ean;
    logic       edp;
    logic [6:0] eseg;
    slot = ph() / 4;
    pos  = ph() % 4;
    ean = 3'b111; edp = 1'b1; eseg = SB;
    if (pos != 0 && !(slot == 2 && blank_min)) begin
      case (slot)
        0:       begin ean = 3'b110; eseg = e0; end
        1:       begin ean = 3'b101; eseg = e1; end
        default: begin ean = 3'b011; eseg = e2; edp = 1'b0; end
      endcase
    end
    if (lz) check(tag, {5'd0, an_b, dp_b, seg_b}, {5'd0, ean, edp, eseg});
    else    check(tag, {5'd0, an_a, dp_a, seg_a}, {5'd0, ean, edp, eseg});
  endtask

  task automatic check_frame(input string tag, input bit lz, input logic [6:0] e0,
                             input logic [6:0] e1, input logic [6:0] e2, input bit blank_min);
    while (ph() != 0) tick();
    for (int i = 0; i < 12; i++) begin
      check_now(tag, lz, e0, e1, e2, blank_min);
      tick();
    end
  endtask

  // Advance past one capture edge, stopping at the start of the next frame.
  task automatic next_frame();
    do tick(); while (ph() != 11);
    tick();
  endtask

  initial begin
    clr_n = 1'b0;
    lap   = 1'b0;
    set_time(4'd0, 4'd0, 4'd0);
    tick(); tick();
    clr_n = 1'b1; k = 0;

    // 1: reset mid-scan while holding
    repeat (5) tick();
    lap = 1'b1; tick(); lap = 1'b0;
    check("hold_before_reset", {15'd0, hold_a}, 16'd1);
    repeat (2) tick();
    clr_n = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("rst_an",   {13'd0, an_a},  16'h0007);
      check("rst_seg",  {9'd0, seg_a},  16'h007f);
      check("rst_dp",   {15'd0, dp_a},  16'h0001);
      check("rst_hold", {15'd0, hold_a}, 16'h0000);
    end
    check("rst_lz_an", {13'd0, an_b}, 16'h0007);
    clr_n = 1'b1; k = 0;
    tick();
    check_now("rst_ghost", 1'b0, S0, S0, S0, 1'b0);
    tick();
    check("rst_first_an",  {13'd0, an_a}, {13'd0, 3'b110});
    check("rst_first_seg", {9'd0, seg_a}, {9'd0, S0});

    // 2: steady scan of 2:47
    set_time(4'd2, 4'd4, 4'd7);
    next_frame();
    check_frame("scan_247", 1'b0, S7, S4, S2, 1'b0);
    check_frame("scan_247b", 1'b0, S7, S4, S2, 1'b0);

    // 3: lap hold and release
    set_time(4'd9, 4'd5, 4'd3);
    next_frame();
    check_frame("scan_953", 1'b0, S3, S5, S9, 1'b0);
    lap = 1'b1; tick(); lap = 1'b0;
    check("hold_set", {15'd0, hold_a}, 16'd1);
    set_time(4'd0, 4'd0, 4'd0);
    while (ph() != 0) begin check_now("hold_rest", 1'b0, S3, S5, S9, 1'b0); tick(); end
    for (int f = 0; f < 5; f++) check_frame("hold_frozen", 1'b0, S3, S5, S9, 1'b0);
    lap = 1'b1; tick(); lap = 1'b0;
    check("hold_clr", {15'd0, hold_a}, 16'd0);
    while (ph() != 0) begin check_now("release_old", 1'b0, S3, S5, S9, 1'b0); tick(); end
    check_frame("release_new", 1'b0, S0, S0, S0, 1'b0);

    // 4a: LAP held high counts once
    set_time(4'd1, 4'd2, 4'd3);
    next_frame();
    lap = 1'b1;
    for (int i = 0; i < 40; i++) begin
      tick();
      check("lap_level", {15'd0, hold_a}, 16'd1);
      if (i == 20) set_time(4'd4, 4'd5, 4'd6);
    end
    lap = 1'b0; tick();
    check("lap_level_end", {15'd0, hold_a}, 16'd1);
    check_frame("lap_level_snap", 1'b0, S3, S2, S1, 1'b0);
    lap = 1'b1; tick(); lap = 1'b0;
    check("lap_level_rel", {15'd0, hold_a}, 16'd0);
    next_frame();
    check_frame("track_456", 1'b0, S6, S5, S4, 1'b0);

    // 4b: LAP rising on the frame-boundary cycle
    set_time(4'd8, 4'd1, 4'd7);
    while (ph() != 10) tick();
    lap = 1'b1; tick(); lap = 1'b0;
    set_time(4'd3, 4'd0, 4'd8);
    check("lap_bound_hold", {15'd0, hold_a}, 16'd1);
    check_now("lap_bound_old", 1'b0, S6, S5, S4, 1'b0);
    tick();
    check_frame("lap_bound_snap", 1'b0, S7, S1, S8, 1'b0);
    check_frame("lap_bound_snap2", 1'b0, S7, S1, S8, 1'b0);
    lap = 1'b1; tick(); lap = 1'b0;
    check("lap_bound_rel", {15'd0, hold_a}, 16'd0);

    // 5: out-of-range minutes shows E
    set_time(4'hC, 4'd3, 4'd0);
    next_frame();
    check_frame("min_err", 1'b0, S0, S3, SE, 1'b0);

    // 6: leading-zero blanking on the BLANK_LZ instance
    set_time(4'd0, 4'd0, 4'd5);
    next_frame();
    check_frame("no_lz_005", 1'b0, S5, S0, S0, 1'b0);
    check_frame("lz_005", 1'b1, S5, S0, S0, 1'b1);
    minutes = 4'd1;
    check_frame("lz_pending", 1'b1, S5, S0, S0, 1'b1);
    check_frame("lz_105", 1'b1, S5, S0, S1, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
